// File: rtl/sp_mul_pkg.sv
// Shared widths, defaults and operand bundle for the shared multiplier.
// Imported by the arbiter top and the multiply core.
package sp_mul_pkg;

  localparam int A_W       = 12;
  localparam int B_W       = 12;
  localparam int P_W       = 23;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = $clog2(N_REQ_DEF);

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } op_t;

endpackage

// File: rtl/sp_mul_dsp_core.sv
// Combinational 12u x 12s multiply, low 23 bits of the signed product.
// Ports: a (unsigned), b (signed), p (wrapped signed product).
module sp_mul_dsp_core
  import sp_mul_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic signed [A_W+B_W:0] full;

  assign full = $signed({1'b0, a}) * $signed(b);
  assign p    = full[P_W-1:0];

endmodule

// File: rtl/sp_mul_share_arb.sv
// Round-robin share of one multiplier among N_REQ requesters, 2-stage pipe.
// Ports: ap_clk/ap_rst_n, req_valid/ready/a/b per requester, res_* out.
module sp_mul_share_arb
  import sp_mul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic [P_W-1:0]     res_p
);

  logic             s1_v;
  logic             s2_v;
  logic             s1_ld;
  logic             s2_ld;
  logic             found;
  logic             acc;
  op_t              s1_op;
  op_t              sel_op;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  s1_id;
  logic [ID_W-1:0]  s2_id;
  logic [P_W-1:0]   s2_p;
  logic [P_W-1:0]   prod;
  logic [N_REQ-1:0] gnt;

  assign s2_ld = !s2_v || res_ready;
  assign s1_ld = !s1_v || s2_ld;

  // Pick the valid index with the smallest distance above rr_ptr.
  always_comb begin
    int off;
    int best;
    off    = 0;
    best   = N_REQ;
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - int'(rr_ptr)) % N_REQ;
      if (req_valid[i] && off < best) begin
        best   = off;
        found  = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    gnt    = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (found && gnt_id == ID_W'(i)) begin
        gnt[i]   = 1'b1;
        sel_op.a = req_a[i*A_W +: A_W];
        sel_op.b = req_b[i*B_W +: B_W];
      end
    end
  end

  // Reset gates ready directly so nothing is granted while held.
  assign acc       = found && s1_ld && ap_rst_n;
  assign req_ready = acc ? gnt : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_op  <= '0;
      s1_id  <= '0;
      s2_v   <= 1'b0;
      s2_id  <= '0;
      s2_p   <= '0;
    end else begin
      if (acc) begin
        rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ?
                  '0 : gnt_id + 1'b1;
      end
      if (s1_ld) begin
        s1_v <= acc;
        if (acc) begin
          s1_op <= sel_op;
          s1_id <= gnt_id;
        end
      end
      if (s2_ld) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_p  <= prod;
          s2_id <= s1_id;
        end
      end
    end
  end

  sp_mul_dsp_core u_mul (
    .a (s1_op.a),
    .b (s1_op.b),
    .p (prod)
  );

  assign res_valid = s2_v;
  assign res_id    = s2_id;
  assign res_p     = s2_p;

endmodule

// File: tb/tb_sp_mul_share_arb.sv
// Random and directed bench for sp_mul_share_arb against a queue model.
// Model: in-flight FIFO of depth 2, rr pointer, arithmetic product.
module tb_sp_mul_share_arb;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*12-1:0] req_a;
  logic [N*12-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [IDW-1:0]  res_id;
  logic [22:0]     res_p;

  always #5 ap_clk = ~ap_clk;

  sp_mul_share_arb #(.N_REQ(N), .ID_W(IDW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [22:0] p;
    int          stamp;
  } item_t;

  item_t q[$];
  int    rr  = 0;
  int    cyc = 0;

  function automatic logic [22:0] ref_mul(input logic [11:0] a,
                                          input logic [11:0] b);
    int pr;
    pr = int'(a) * int'($signed(b));
    return pr[22:0];
  endfunction

  task automatic set_req(input int i, input logic [11:0] a,
                         input logic [11:0] b);
    req_a[i*12 +: 12] = a;
    req_b[i*12 +: 12] = b;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++)
      set_req(i, 12'($urandom), 12'($urandom));
  endtask

  // One clock: check outputs at negedge, advance model at posedge.
  task automatic cycle();
    int          g;
    bit          ok;
    bit          outv;
    logic [N-1:0] exp_rdy;
    item_t       it;
    @(negedge ap_clk);
    ok   = (q.size() < 2) || res_ready;
    g    = -1;
    if (ok) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    outv = (q.size() > 0) && (cyc > q[0].stamp);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(outv));
    if (outv) begin
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_p", 32'(res_p), 32'(q[0].p));
    end
    @(posedge ap_clk);
    cyc++;
    if (outv && res_ready) void'(q.pop_front());
    if (g >= 0) begin
      it.id    = g;
      it.p     = ref_mul(req_a[g*12 +: 12], req_b[g*12 +: 12]);
      it.stamp = cyc;
      q.push_back(it);
      rr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_p", 32'(res_p), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    rr = 0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_hold_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("init_res_valid", 32'(res_valid), 32'd0);
    chk("init_res_p", 32'(res_p), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    @(posedge ap_clk);
    #1;

    // single op: 3 * -5
    set_req(0, 12'd3, -12'sd5);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // wrap boundaries, back to back
    req_valid = 4'b0001;
    set_req(0, 12'd4095, 12'd2047);
    cycle();
    set_req(0, 12'd4095, 12'h800);
    cycle();
    set_req(0, 12'd0, 12'h800);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // fairness: all valid 8 cycles
    req_valid = '1;
    repeat (8) begin
      rand_data();
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // backpressure then release
    req_valid = '1;
    res_ready = 1'b0;
    repeat (5) begin
      rand_data();
      cycle();
    end
    res_ready = 1'b1;
    repeat (4) begin
      rand_data();
      cycle();
    end
    req_valid = '0;
    repeat (4) cycle();

    // sparse: rr -> 3 via req 2, then reqs 1 and 2
    req_valid = 4'b0100;
    rand_data();
    cycle();
    req_valid = 4'b0110;
    repeat (2) begin
      rand_data();
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();

    // reset with two ops in flight
    req_valid = '1;
    repeat (2) begin
      rand_data();
      cycle();
    end
    do_reset();
    req_valid = '1;
    rand_data();
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rand_data();
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_mul_share_arb.md
SP_MUL_SHARE_ARB -- requirements
Module: sp_mul_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one multiplier (legal range 2..8).
REQ-002 SHALL have parameter ID_W, default 2, giving the requester-id width (equal to clog2(N_REQ)).
REQ-003 ap_clk  input  1  single clock; all state on rising edge.
REQ-004 ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester operand-valid.
REQ-006 req_ready  output  N_REQ  per-requester accept (one-hot or zero).
REQ-007 req_a  input  N_REQ*12  per-requester operand A, unsigned; slice i = bits [12i+11:12i].
REQ-008 req_b  input  N_REQ*12  per-requester operand B, two's-complement signed; same slicing.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_ready  input  1  downstream accept.
REQ-011 res_id  output  ID_W  index of requester that issued the result.
REQ-012 res_p  output  23  signed product.

Function
REQ-013 SHALL accept a request from requester i on a cycle where req_valid[i] && req_ready[i].
REQ-014 SHALL assert at most one req_ready bit per cycle; req_ready may depend combinationally on req_valid.
REQ-015 Arbitration SHALL be round-robin: search from pointer rr_ptr upward with wrap; grant the first valid index.
REQ-016 On acceptance from index i, rr_ptr SHALL become (i+1) mod N_REQ; otherwise rr_ptr SHALL hold.
REQ-017 SHALL be a 2-stage pipeline: S1 registers {a, b, id, valid}; S2 registers {p, id, valid}, driving res_*.
REQ-018 S2 SHALL load when !res_valid || res_ready; S1 SHALL load when S1 empty or S2 loads.
REQ-019 req_ready SHALL be all-zero whenever S1 cannot load.
REQ-020 Latency SHALL be 2 cycles: acceptance at edge k gives res_valid at edge k+1 when unstalled, i.e. visible after edge k+2 sampling; throughput SHALL be 1 result/cycle.
REQ-021 res_p SHALL equal the low 23 bits of signed({1'b0,a}) * signed(b); no saturation (24-bit product wraps).
REQ-022 While res_valid && !res_ready, res_p/res_id/res_valid SHALL hold stable.
REQ-023 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-024 With no valid requester, rr_ptr SHALL hold and the pipeline SHALL drain normally.
REQ-025 Same-cycle S2 output consumption and S1 acceptance SHALL sustain full throughput without bubbles.

Reset
REQ-026 On ap_rst_n low, S1/S2 valid flags SHALL clear immediately; res_valid=0, res_id=0, res_p=0, rr_ptr=0.
REQ-027 While reset asserted, req_ready SHALL be all-zero.
REQ-028 Reset mid-operation SHALL discard in-flight operations; first grant after release SHALL search from index 0.

Structure
REQ-029 Package sp_mul_pkg SHALL hold A_W=12, B_W=12, P_W=23, default N_REQ, and ID_W derivation.
REQ-030 Multiply SHALL live in one combinational sub-module sp_mul_dsp_core (12 unsigned x 12 signed -> 23), instantiated once between S1 and S2.
REQ-031 Arbiter, rr_ptr and pipeline control SHALL reside in sp_mul_share_arb.

Verification
REQ-032 Single op: req 0 a=3, b=-5, res_ready=1 -> one res_valid with res_id=0, res_p=-15, 2 cycles after accept.
REQ-033 Wrap boundary: a=4095, b=2047 -> res_p=-6143; a=4095, b=-2048 -> res_p=2048; a=0, b=-2048 -> 0.
REQ-034 Fairness: all 4 req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one accept per cycle.
REQ-035 Backpressure: res_ready=0 for 5 cycles with requests pending -> S1 and S2 fill, req_ready=0, outputs stable, no loss; release -> results in order.
REQ-036 Sparse/skip: only req 2 then req 1 valid, rr_ptr=3 -> grant 1 first (wrap), then 2.
REQ-037 Reset mid-stream: assert ap_rst_n low with 2 ops in flight -> res_valid=0 at once, no stale result after release, first grant from index 0.
